// File: rtl/xmem_arbiter.sv
// Two-master Wishbone classic arbiter for the shared 32-bit external-memory slave.
// Round-robin with bus hold, plus bounded-burst preemption on transaction boundaries.
module xmem_arbiter #(
    parameter int MAX_BURST = 16,
    parameter int CNT_BITS  = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:31] m0_adr_i,
    input  logic [0:31] m0_dat_i,
    output logic [0:31] m0_dat_o,
    input  logic        m0_we_i,
    input  logic [0:3]  m0_sel_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic        m0_ack_o,
    input  logic [2:31] m1_adr_i,
    input  logic [0:31] m1_dat_i,
    output logic [0:31] m1_dat_o,
    input  logic        m1_we_i,
    input  logic [0:3]  m1_sel_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic        m1_ack_o,
    output logic [2:31] s_adr_o,
    output logic [0:31] s_dat_o,
    input  logic [0:31] s_dat_i,
    output logic        s_we_o,
    output logic [0:3]  s_sel_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic        s_ack_i,
    output logic [1:0]  grant,
    output logic [15:0] preempt_cnt
);

    // Encodings double as the one-hot grant output.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_t;

    state_t              state, state_next;
    logic                last, last_next;
    logic [CNT_BITS-1:0] burst_cnt;
    logic                burst_full;
    logic                other_cyc;
    logic                preempt;

    assign grant      = state;
    assign m0_dat_o   = s_dat_i;
    assign m1_dat_o   = s_dat_i;
    assign burst_full = (MAX_BURST > 0) && ((int'(burst_cnt) + 1) >= MAX_BURST);

    always_comb begin
        other_cyc = 1'b0;
        case (state)
            G0:      other_cyc = m1_cyc_i;
            G1:      other_cyc = m0_cyc_i;
            default: other_cyc = 1'b0;
        endcase
    end

    // Preemption is only taken on an ack cycle, so an in-flight transfer always completes.
    always_comb begin
        state_next = state;
        last_next  = last;
        preempt    = 1'b0;
        case (state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) state_next = last ? G0 : G1;
                else if (m0_cyc_i)        state_next = G0;
                else if (m1_cyc_i)        state_next = G1;
            end
            G0: begin
                if (!m0_cyc_i) begin
                    last_next  = 1'b0;
                    state_next = m1_cyc_i ? G1 : IDLE;
                end else if (s_ack_i && burst_full && m1_cyc_i) begin
                    preempt    = 1'b1;
                    last_next  = 1'b0;
                    state_next = G1;
                end
            end
            G1: begin
                if (!m1_cyc_i) begin
                    last_next  = 1'b1;
                    state_next = m0_cyc_i ? G0 : IDLE;
                end else if (s_ack_i && burst_full && m0_cyc_i) begin
                    preempt    = 1'b1;
                    last_next  = 1'b1;
                    state_next = G0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last        <= 1'b1;
            burst_cnt   <= '0;
            preempt_cnt <= '0;
        end else begin
            state <= state_next;
            last  <= last_next;
            if (state_next != state)
                burst_cnt <= '0;
            else if (s_ack_i && other_cyc && (burst_cnt != '1))
                burst_cnt <= burst_cnt + 1'b1;
            if (preempt && (preempt_cnt != '1))
                preempt_cnt <= preempt_cnt + 1'b1;
        end
    end

    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_stb_o  = 1'b0;
        s_cyc_o  = 1'b0;
        m0_ack_o = 1'b0;
        m1_ack_o = 1'b0;
        case (state)
            G0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_stb_o  = m0_stb_i;
                s_cyc_o  = m0_cyc_i;
                m0_ack_o = s_ack_i;
            end
            G1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_stb_o  = m1_stb_i;
                s_cyc_o  = m1_cyc_i;
                m1_ack_o = s_ack_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_xmem_arbiter.sv
// Directed bench for xmem_arbiter with MAX_BURST=4; the slave side is driven by hand.
module tb_xmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:31] m0_adr_i, m1_adr_i, s_adr_o;
    logic [0:31] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic        m0_we_i, m1_we_i, s_we_o;
    logic [0:3]  m0_sel_i, m1_sel_i, s_sel_o;
    logic        m0_stb_i, m0_cyc_i, m0_ack_o;
    logic        m1_stb_i, m1_cyc_i, m1_ack_o;
    logic        s_stb_o, s_cyc_o, s_ack_i;
    logic [1:0]  grant;
    logic [15:0] preempt_cnt;

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    xmem_arbiter #(.MAX_BURST(4), .CNT_BITS(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_we_i(m0_we_i),
        .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_ack_o(m0_ack_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_we_i(m1_we_i),
        .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_we_o(s_we_o),
        .s_sel_o(s_sel_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i),
        .grant(grant), .preempt_cnt(preempt_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        m0_adr_i = 30'h0000100; m0_dat_i = 32'h11110000; m0_we_i = 1'b0; m0_sel_i = 4'hF;
        m1_adr_i = 30'h0000200; m1_dat_i = 32'h22220000; m1_we_i = 1'b0; m1_sel_i = 4'h3;
        m0_stb_i = 1'b0; m0_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_cyc_i = 1'b0;
        s_dat_i  = 32'hCAFE0000; s_ack_i = 1'b1;
        settle();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_scyc", 32'(s_cyc_o), 32'h0);
        chk("rst_sstb", 32'(s_stb_o), 32'h0);
        chk("rst_acks", {30'h0, m1_ack_o, m0_ack_o}, 32'h0);
        chk("rst_pcnt", 32'(preempt_cnt), 32'h0);
        tick();
        rst_n = 1'b1; s_ack_i = 1'b0;
        tick();

        // Single master: m0 alone, four reads.
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        settle();
        chk("single_latency", 32'(grant), 32'h0);
        tick();
        chk("single_grant", 32'(grant), 32'h1);
        chk("single_adr", 32'(s_adr_o), 32'h0000100);
        s_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_dat_i = 32'hA0000000 + 32'(i);
            settle();
            chk("single_ack0", 32'(m0_ack_o), 32'h1);
            chk("single_ack1", 32'(m1_ack_o), 32'h0);
            chk("single_dat", 32'(m0_dat_o), 32'hA0000000 + 32'(i));
            tick();
            chk("single_hold", 32'(grant), 32'h1);
        end
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        chk("single_idle", 32'(grant), 32'h0);
        chk("single_pcnt", 32'(preempt_cnt), 32'h0);

        // Simultaneous first request after a fresh reset: m0 wins.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        chk("tie_grant", 32'(grant), 32'h1);
        chk("tie_adr", 32'(s_adr_o), 32'h0000100);
        s_ack_i = 1'b1;
        settle();
        chk("tie_ack0", 32'(m0_ack_o), 32'h1);
        chk("tie_ack1", 32'(m1_ack_o), 32'h0);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        settle();
        chk("tie_hold", 32'(grant), 32'h1);
        tick();
        chk("tie_handover", 32'(grant), 32'h2);
        chk("tie_adr1", 32'(s_adr_o), 32'h0000200);
        chk("tie_sel1", 32'(s_sel_o), 32'h3);

        // Round-robin with one transfer per cycle; m1 currently holds the bus.
        for (int i = 0; i < 4; i++) begin
            m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
            s_ack_i  = 1'b1;
            settle();
            chk("rr_grant", 32'(grant), (i % 2 == 0) ? 32'h2 : 32'h1);
            chk("rr_ack0", 32'(m0_ack_o), (i % 2 == 0) ? 32'h0 : 32'h1);
            chk("rr_ack1", 32'(m1_ack_o), (i % 2 == 0) ? 32'h1 : 32'h0);
            tick();
            s_ack_i = 1'b0;
            if (i % 2 == 0) begin
                m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
            end else begin
                m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
            end
            tick();
            chk("rr_next", 32'(grant), (i % 2 == 0) ? 32'h1 : 32'h2);
        end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        chk("rr_idle", 32'(grant), 32'h0);

        // Preemption: m0 writes continuously while m1 waits.
        m0_we_i = 1'b1; m0_dat_i = 32'h5A5A0001;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        chk("pre_grant", 32'(grant), 32'h1);
        chk("pre_we", 32'(s_we_o), 32'h1);
        chk("pre_wdat", 32'(s_dat_o), 32'h5A5A0001);
        s_ack_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("pre_ack0", 32'(m0_ack_o), 32'h1);
            chk("pre_ack1", 32'(m1_ack_o), 32'h0);
            tick();
            chk("pre_grant_after", 32'(grant), (i < 3) ? 32'h1 : 32'h2);
        end
        chk("pre_pcnt", 32'(preempt_cnt), 32'h1);
        s_ack_i = 1'b0;
        settle();
        chk("pre_masked_stb", 32'(s_we_o), 32'h0);
        chk("pre_m1_adr", 32'(s_adr_o), 32'h0000200);

        // Slave wait states on an m1 read while m0 keeps requesting.
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("ws_hold", 32'(grant), 32'h2);
            chk("ws_ack0", 32'(m0_ack_o), 32'h0);
        end
        s_ack_i = 1'b1; s_dat_i = 32'hDEADBEEF;
        settle();
        chk("ws_ack1", 32'(m1_ack_o), 32'h1);
        chk("ws_dat1", 32'(m1_dat_o), 32'hDEADBEEF);
        chk("ws_noack0", 32'(m0_ack_o), 32'h0);
        tick();
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        chk("ws_handover", 32'(grant), 32'h1);
        chk("ws_pcnt", 32'(preempt_cnt), 32'h1);

        // Asynchronous reset while m0 has a strobe out.
        chk("rstm_stb_before", 32'(s_stb_o), 32'h1);
        #2;
        s_ack_i = 1'b1;
        rst_n   = 1'b0;
        settle();
        chk("rstm_scyc", 32'(s_cyc_o), 32'h0);
        chk("rstm_sstb", 32'(s_stb_o), 32'h0);
        chk("rstm_grant", 32'(grant), 32'h0);
        chk("rstm_pcnt", 32'(preempt_cnt), 32'h0);
        chk("rstm_ack0", 32'(m0_ack_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
